// File: rtl/merge_rr_buffered.sv
// ---------------------------------------------------------------------------
// merge_rr_buffered
//
// Merges INPUTS data-carrying handshake channels into one output channel.
// A round-robin arbiter picks one valid input per cycle and grants ready to
// that input only. Accepted tokens land in a two-entry buffer (main + skid):
// outs/index/outs_valid are driven straight from the main slot, and input
// acceptance depends only on the registered skid occupancy. That keeps
// outs_ready out of the ins_ready cone while still sustaining one token per
// cycle.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   ins         packed input data, channel i at [i*DATA_TYPE +: DATA_TYPE]
//   ins_valid   per-channel valid
//   ins_ready   per-channel ready, one-hot or zero (winner only)
//   outs        output data (main slot)
//   outs_valid  main slot occupied
//   outs_ready  downstream ready
//   index       input number that produced the current outs
// ---------------------------------------------------------------------------
module merge_rr_buffered #(
  parameter int INPUTS     = 2,
  parameter int DATA_TYPE  = 32,
  parameter int INDEX_TYPE = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INPUTS*DATA_TYPE-1:0]   ins,
  input  logic [INPUTS-1:0]             ins_valid,
  output logic [INPUTS-1:0]             ins_ready,
  output logic [DATA_TYPE-1:0]          outs,
  output logic                          outs_valid,
  input  logic                          outs_ready,
  output logic [INDEX_TYPE-1:0]         index
);

  // Buffer occupancy encoded as {main_v, skid_v}.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] TWO   = 2'b11;

  logic [INDEX_TYPE-1:0] ptr;
  logic [INDEX_TYPE-1:0] winner;
  logic [INDEX_TYPE-1:0] ptr_nxt;
  logic [DATA_TYPE-1:0]  win_data;
  logic                  any_valid;
  logic                  can_accept;
  logic                  in_xfer;
  logic                  out_xfer;

  logic                  main_v;
  logic [DATA_TYPE-1:0]  main_data;
  logic [INDEX_TYPE-1:0] main_idx;
  logic                  skid_v;
  logic [DATA_TYPE-1:0]  skid_data;
  logic [INDEX_TYPE-1:0] skid_idx;

  // Round-robin pick: scan from ptr upward with wrap. The scan runs from the
  // farthest offset back to offset 0 so the nearest valid input is the last
  // assignment and therefore wins.
  always_comb begin
    int j;
    j      = 0;
    winner = ptr;
    for (int k = INPUTS - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % INPUTS;
      if (ins_valid[j]) winner = INDEX_TYPE'(j);
    end
  end

  assign any_valid  = |ins_valid;
  assign can_accept = !skid_v;
  assign win_data   = ins[int'(winner)*DATA_TYPE +: DATA_TYPE];

  always_comb begin
    ins_ready = '0;
    for (int i = 0; i < INPUTS; i++) begin
      ins_ready[i] = rst & can_accept & any_valid & (int'(winner) == i);
    end
  end

  assign in_xfer  = |(ins_valid & ins_ready);
  assign out_xfer = main_v & outs_ready;

  always_comb begin
    if (int'(winner) == INPUTS - 1) ptr_nxt = '0;
    else                            ptr_nxt = winner + INDEX_TYPE'(1);
  end

  assign outs       = main_data;
  assign index      = main_idx;
  assign outs_valid = main_v;

  // Buffer update: data and index always move as a pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      main_v    <= 1'b0;
      main_data <= '0;
      main_idx  <= '0;
      skid_v    <= 1'b0;
      skid_data <= '0;
      skid_idx  <= '0;
    end else begin
      if (in_xfer) ptr <= ptr_nxt;
      case ({main_v, skid_v})
        EMPTY: begin
          if (in_xfer) begin
            main_v    <= 1'b1;
            main_data <= win_data;
            main_idx  <= winner;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_v    <= 1'b1;
            skid_data <= win_data;
            skid_idx  <= winner;
          end else if (in_xfer && out_xfer) begin
            main_data <= win_data;
            main_idx  <= winner;
          end else if (out_xfer) begin
            main_v <= 1'b0;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_data <= skid_data;
            main_idx  <= skid_idx;
            skid_v    <= 1'b0;
          end
        end
        default: begin
          // Skid without main cannot be reached; drop it to recover.
          skid_v <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_merge_rr_buffered.sv
module tb_merge_rr_buffered;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 4-input instance: model-checked every cycle
  logic [31:0] ins4;
  logic [3:0]  v4, r4;
  logic [7:0]  o4;
  logic        ov4, or4;
  logic [1:0]  idx4;

  // 3-input instance: directed sequences with literal expectations
  logic [23:0] ins3;
  logic [2:0]  v3, r3;
  logic [7:0]  o3;
  logic        ov3, or3;
  logic [1:0]  idx3;

  merge_rr_buffered #(.INPUTS(4), .DATA_TYPE(8)) u4 (
    .clk(clk), .rst(rst), .ins(ins4), .ins_valid(v4), .ins_ready(r4),
    .outs(o4), .outs_valid(ov4), .outs_ready(or4), .index(idx4)
  );

  merge_rr_buffered #(.INPUTS(3), .DATA_TYPE(8)) u3 (
    .clk(clk), .rst(rst), .ins(ins3), .ins_valid(v3), .ins_ready(r3),
    .outs(o3), .outs_valid(ov3), .outs_ready(or3), .index(idx3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model of u4 ----------------
  // The merge is a FIFO of capacity 2 whose head is the output; an input is
  // accepted only while fewer than 2 tokens are held.
  typedef struct packed {
    logic [7:0] d;
    logic [1:0] i;
  } tok_t;

  tok_t       q[$];
  int         ptr_m = 0;
  logic       m_in = 1'b0;
  logic       m_out = 1'b0;
  int         m_w = -1;
  logic [7:0] m_d = '0;
  logic [3:0] v_snap = '0;
  logic [3:0] exp_rdy;
  int         wt[4] = '{0, 0, 0, 0};
  int         jj;

  always @(negedge clk) begin
    m_in  = 1'b0;
    m_out = 1'b0;
    m_w   = -1;
    if (!rst) begin
      chk("rst_outs_valid", 32'(ov4), 32'd0);
      chk("rst_ins_ready", 32'(r4), 32'd0);
      chk("rst_index", 32'(idx4), 32'd0);
      chk("rst_outs", 32'(o4), 32'd0);
    end else begin
      chk("model_outs_valid", 32'(ov4), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("model_outs", 32'(o4), 32'(q[0].d));
        chk("model_index", 32'(idx4), 32'(q[0].i));
      end
      for (int k = 0; k < 4; k++) begin
        jj = (ptr_m + k) % 4;
        if (m_w < 0 && v4[jj]) m_w = jj;
      end
      exp_rdy = (q.size() < 2 && m_w >= 0) ? (4'b0001 << m_w) : 4'b0000;
      chk("model_ins_ready", 32'(r4), 32'(exp_rdy));
      m_in   = (exp_rdy != 4'b0000);
      m_out  = (q.size() > 0) && or4;
      if (m_w >= 0) m_d = ins4[m_w*8 +: 8];
      v_snap = v4;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      ptr_m = 0;
      for (int i = 0; i < 4; i++) wt[i] = 0;
    end else begin
      if (m_out) void'(q.pop_front());
      if (m_in) begin
        q.push_back('{d: m_d, i: 2'(m_w)});
        ptr_m = (m_w + 1) % 4;
        for (int i = 0; i < 4; i++) begin
          if (i == m_w) begin
            chk("fairness_wait", 32'(wt[i] <= 3), 32'd1);
            wt[i] = 0;
          end else if (v_snap[i]) begin
            wt[i]++;
          end else begin
            wt[i] = 0;
          end
        end
      end else begin
        for (int i = 0; i < 4; i++) if (!v_snap[i]) wt[i] = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst  = 1'b0;
    v4   = 4'b1111; ins4 = 32'h44332211; or4 = 1'b0;
    v3   = 3'b111;  ins3 = 24'h302010;   or3 = 1'b1;

    // Reset held with everything valid
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t1_outs_valid4", 32'(ov4), 32'd0);
      chk("t1_ins_ready4", 32'(r4), 32'd0);
      chk("t1_index4", 32'(idx4), 32'd0);
      chk("t1_outs_valid3", 32'(ov3), 32'd0);
      chk("t1_ins_ready3", 32'(r3), 32'd0);
    end
    tick();
    rst = 1'b1;
    or4 = 1'b1;
    @(negedge clk);
    chk("t1_first_grant4", 32'(r4), 32'h1);
    chk("t1_first_grant3", 32'(r3), 32'h1);
    chk("t2_empty3", 32'(ov3), 32'd0);
    tick();
    v4 = 4'b0000;

    // Round-robin streaming on the 3-input instance
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("t2_outs_valid", 32'(ov3), 32'd1);
      chk("t2_index", 32'(idx3), 32'((c - 1) % 3));
      chk("t2_outs", 32'(o3), 32'(((c - 1) % 3 + 1) * 16));
      chk("t2_ins_ready", 32'(r3), 32'(3'b001 << (c % 3)));
      tick();
    end
    v3 = 3'b000;
    tick();
    tick();

    // Pointer wrap
    v3 = 3'b010;
    @(negedge clk); chk("t4_grant1", 32'(r3), 32'h2); tick();
    v3 = 3'b001;
    @(negedge clk); chk("t4_grant0_wrap", 32'(r3), 32'h1); tick();
    v3 = 3'b101;
    @(negedge clk); chk("t4_ptr_is_1", 32'(r3), 32'h4); tick();
    v3 = 3'b111;
    @(negedge clk); chk("t4_ptr_is_0", 32'(r3), 32'h1); tick();
    v3 = 3'b000;

    // Backpressure on the 4-input instance
    v4 = 4'b0001; ins4[7:0] = 8'h0A; or4 = 1'b0;
    @(negedge clk); chk("t3_accept_a", 32'(r4), 32'h1); tick();
    ins4[7:0] = 8'h0B;
    @(negedge clk);
    chk("t3_accept_b", 32'(r4), 32'h1);
    chk("t3_outs_a", 32'(o4), 32'h0A);
    tick();
    ins4[7:0] = 8'h0C;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t3_full_no_ready", 32'(r4), 32'h0);
      chk("t3_outs_stable", 32'(o4), 32'h0A);
      chk("t3_valid_stable", 32'(ov4), 32'd1);
      tick();
    end
    v4 = 4'b0000; or4 = 1'b1;
    @(negedge clk); chk("t3_drain_a", 32'(o4), 32'h0A); tick();
    @(negedge clk);
    chk("t3_drain_b", 32'(o4), 32'h0B);
    chk("t3_drain_b_valid", 32'(ov4), 32'd1);
    tick();
    @(negedge clk); chk("t3_drained", 32'(ov4), 32'd0); tick();

    // Simultaneous in/out while holding one token
    v4 = 4'b0001; ins4[7:0] = 8'h55; or4 = 1'b1;
    tick();
    ins4[7:0] = 8'h66;
    @(negedge clk);
    chk("t5_can_accept", 32'(r4), 32'h1);
    chk("t5_outs_old", 32'(o4), 32'h55);
    tick();
    ins4[7:0] = 8'h77; or4 = 1'b0;
    @(negedge clk);
    chk("t5_outs_new", 32'(o4), 32'h66);
    chk("t5_skid_empty", 32'(r4), 32'h1);
    tick();
    v4 = 4'b0000; or4 = 1'b1;
    tick(); tick(); tick();

    // Random traffic, with a reset pulse in the middle
    for (int c = 0; c < 10000; c++) begin
      v4   = 4'($urandom);
      ins4 = $urandom;
      or4  = ($urandom_range(0, 3) != 0);
      if (c == 5000) rst = 1'b0;
      if (c == 5002) rst = 1'b1;
      tick();
    end
    v4 = 4'b0000; or4 = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("final_empty", 32'(ov4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
